// File: rtl/wired_rob_ptr_ctrl_if.sv
// wired_rob_ptr_ctrl_if
// Dispatch/commit-side bundle between rename/dispatch, the ROB pointer
// controller and the ROB storage array. Slot0 of every 2-wide field is the
// oldest instruction; packed ids are {slot1, slot0}.
// The slave modport is the pointer controller; the master modport is the
// surrounding pipeline that drives requests and consumes ids.
interface wired_rob_ptr_ctrl_if #(
    parameter int ROB_LEN = 6
);
    logic                   flush_i;
    logic [1:0]             p_req_i;
    logic                   p_ready_o;
    logic [1:0]             p_valid_o;
    logic [2*ROB_LEN-1:0]   p_rid_o;
    logic [1:0]             c_retire_i;
    logic [2*ROB_LEN-1:0]   c_rrrid_o;
    logic [ROB_LEN:0]       count_o;
    logic                   empty_o;
    logic                   err_o;

    modport master (
        output flush_i,
        output p_req_i,
        output c_retire_i,
        input  p_ready_o,
        input  p_valid_o,
        input  p_rid_o,
        input  c_rrrid_o,
        input  count_o,
        input  empty_o,
        input  err_o
    );

    modport slave (
        input  flush_i,
        input  p_req_i,
        input  c_retire_i,
        output p_ready_o,
        output p_valid_o,
        output p_rid_o,
        output c_rrrid_o,
        output count_o,
        output empty_o,
        output err_o
    );
endinterface

// File: rtl/wired_rob_ptr_ctrl.sv
// wired_rob_ptr_ctrl
// ROB pointer and allocation controller. Grants up to two ROB ids per cycle
// to in-order dispatch (combinational grant from registered ready), retires
// up to two entries per cycle from the head, and presents the two oldest ids
// to the ROB commit-side read ports.
// head/tail carry one extra wrap-phase MSB so full and empty are distinct;
// occupancy is kept explicitly as count_q == tail_q - head_q.
// Optional macro WIRED_ROB_PTR_CHECK_EN builds a sticky protocol checker on
// err_o; without it err_o is tied low and illegal inputs are not guarded.
module wired_rob_ptr_ctrl #(
    parameter int ROB_LEN = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    wired_rob_ptr_ctrl_if.slave   rob
);
    localparam int PW = ROB_LEN + 1;
    localparam logic [PW-1:0] DEPTH     = {1'b1, {ROB_LEN{1'b0}}};
    // Highest occupancy at which two more entries are still free
    localparam logic [PW-1:0] READY_MAX = DEPTH - PW'(2);

    logic [PW-1:0]      head_q, tail_q, count_q;
    logic [PW-1:0]      head_d, tail_d, count_d;
    logic               ready_q, ready_d;
    logic [1:0]         p_valid, r_valid;
    logic [PW-1:0]      n_alloc, n_ret;
    logic [ROB_LEN-1:0] tail_lo, head_lo;

    // Grant/retire qualification and next-state pointer arithmetic
    always_comb begin
        p_valid = rob.p_req_i & {2{ready_q & ~rob.flush_i}};
        r_valid = rob.c_retire_i & {2{~rob.flush_i}};
        n_alloc = PW'(p_valid[0]) + PW'(p_valid[1]);
        n_ret   = PW'(r_valid[0]) + PW'(r_valid[1]);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ready_d = ready_q;
        if (rob.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ready_d = 1'b1;
        end else begin
            tail_d  = tail_q + n_alloc;
            head_d  = head_q + n_ret;
            count_d = count_q + n_alloc - n_ret;
            // Retired entries only free space for the following cycle's grant
            ready_d = (count_d <= READY_MAX);
        end
    end

    // Pointer, occupancy and ready state
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign tail_lo       = tail_q[ROB_LEN-1:0];
    assign head_lo       = head_q[ROB_LEN-1:0];
    assign rob.p_valid_o = p_valid;
    assign rob.p_rid_o   = {tail_lo + ROB_LEN'(1), tail_lo};
    assign rob.c_rrrid_o = {head_lo + ROB_LEN'(1), head_lo};
    assign rob.count_o   = count_q;
    assign rob.empty_o   = (count_q == '0);
    assign rob.p_ready_o = ready_q;

`ifdef WIRED_ROB_PTR_CHECK_EN
    logic err_q;
    logic chk_hit;

    // Protocol violations; a flush cycle is exempt since it discards everything
    always_comb begin
        chk_hit = ~rob.flush_i & (
                      (n_ret > count_q)
                    | (rob.p_req_i == 2'b10)
                    | (rob.c_retire_i == 2'b10)
                    | ((rob.p_req_i != 2'b00) & ~ready_q));
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (chk_hit) begin
            err_q <= 1'b1;
        end
    end

    assign rob.err_o = err_q;
`else
    assign rob.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wired_rob_ptr_ctrl.sv
// tb_wired_rob_ptr_ctrl
// Directed bench for wired_rob_ptr_ctrl with ROB_LEN = 4 (DEPTH = 16).
// Packed ids are {slot1, slot0}, so {1,0} reads as 16 and {15,14} as 254.
// Expected err_o follows WIRED_ROB_PTR_CHECK_EN when the bench is compiled.
module tb_wired_rob_ptr_ctrl;
    localparam int RL = 4;
`ifdef WIRED_ROB_PTR_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   h;
    int   t;

    wired_rob_ptr_ctrl_if #(.ROB_LEN(RL)) rif ();

    wired_rob_ptr_ctrl #(.ROB_LEN(RL)) dut (
        .clk (clk),
        .rst (rst),
        .rob (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] ret, input logic fl);
        rif.p_req_i    = req;
        rif.c_retire_i = ret;
        rif.flush_i    = fl;
        #1;
    endtask

    function automatic int ids(input int s1, input int s0);
        return ((s1 % 16) << 4) | (s0 % 16);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        rif.p_req_i    = 2'b00;
        rif.c_retire_i = 2'b00;
        rif.flush_i    = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        drive(2'b00, 2'b00, 1'b0);
        chk("rst_ready", int'(rif.p_ready_o), 1);
        chk("rst_empty", int'(rif.empty_o), 1);
        chk("rst_rrrid", int'(rif.c_rrrid_o), 16);
        chk("rst_count", int'(rif.count_o), 0);
        chk("rst_err", int'(rif.err_o), 0);
        chk("rst_pvalid", int'(rif.p_valid_o), 0);
        chk("rst_prid", int'(rif.p_rid_o), 16);

        // Fill to 14 with paired allocations
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 2'b00, 1'b0);
            chk("fill_pvalid", int'(rif.p_valid_o), 3);
            chk("fill_prid", int'(rif.p_rid_o), ids(2*i+1, 2*i));
            tick();
            chk("fill_count", int'(rif.count_o), 2*i+2);
            chk("fill_rrrid", int'(rif.c_rrrid_o), 16);
        end
        chk("fill_ready14", int'(rif.p_ready_o), 1);
        chk("fill_empty", int'(rif.empty_o), 0);

        // Single alloc at count 14 -> 15, no longer two free
        drive(2'b01, 2'b00, 1'b0);
        chk("c1_pvalid", int'(rif.p_valid_o), 1);
        chk("c1_prid", int'(rif.p_rid_o), 254);
        tick();
        chk("c1_count", int'(rif.count_o), 15);
        chk("c1_ready", int'(rif.p_ready_o), 0);

        // Retire one -> head 1, count 14, ready again
        drive(2'b00, 2'b01, 1'b0);
        tick();
        chk("c2_count", int'(rif.count_o), 14);
        chk("c2_rrrid", int'(rif.c_rrrid_o), ids(2, 1));
        chk("c2_ready", int'(rif.p_ready_o), 1);

        // Alloc at tail 15 with simultaneous retire; tail wraps to phase 1
        drive(2'b01, 2'b01, 1'b0);
        chk("c3_pvalid", int'(rif.p_valid_o), 1);
        chk("c3_prid", int'(rif.p_rid_o), ids(0, 15));
        tick();
        drive(2'b00, 2'b00, 1'b0);
        chk("c3_prid_wrap", int'(rif.p_rid_o), 16);
        chk("c3_count", int'(rif.count_o), 14);
        chk("c3_rrrid", int'(rif.c_rrrid_o), ids(3, 2));
        chk("c3_ready", int'(rif.p_ready_o), 1);

        // Two allocs at count 14, no retire -> full
        drive(2'b11, 2'b00, 1'b0);
        chk("c4_pvalid", int'(rif.p_valid_o), 3);
        chk("c4_prid", int'(rif.p_rid_o), 16);
        tick();
        chk("c4_count", int'(rif.count_o), 16);
        chk("c4_ready", int'(rif.p_ready_o), 0);
        chk("c4_empty", int'(rif.empty_o), 0);
        chk("c4_err", int'(rif.err_o), 0);

        // Request while full is dropped
        drive(2'b11, 2'b00, 1'b0);
        chk("c5_pvalid", int'(rif.p_valid_o), 0);
        tick();
        chk("c5_count", int'(rif.count_o), 16);
        chk("c5_err", int'(rif.err_o), CHK);

        // Retire two -> count 14, head 4
        drive(2'b00, 2'b11, 1'b0);
        tick();
        chk("c6_count", int'(rif.count_o), 14);
        chk("c6_rrrid", int'(rif.c_rrrid_o), ids(5, 4));
        chk("c6_ready", int'(rif.p_ready_o), 1);

        // Alloc one + retire one -> head 5, tail 19 (low 3)
        drive(2'b01, 2'b01, 1'b0);
        chk("c7_prid", int'(rif.p_rid_o), ids(3, 2));
        tick();
        chk("c7_count", int'(rif.count_o), 14);
        chk("c7_rrrid", int'(rif.c_rrrid_o), ids(6, 5));

        // Steady alloc 2 / retire 2; odd head passes through 15
        h = 5;
        t = 3;
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, 2'b11, 1'b0);
            chk("wrap_pvalid", int'(rif.p_valid_o), 3);
            chk("wrap_prid", int'(rif.p_rid_o), ids(t+1, t));
            tick();
            t = (t + 2) % 16;
            h = (h + 2) % 16;
            chk("wrap_count", int'(rif.count_o), 14);
            chk("wrap_rrrid", int'(rif.c_rrrid_o), ids(h+1, h));
        end
        chk("wrap_head_end", int'(rif.c_rrrid_o), ids(14, 13));

        // Drain to 9: retire 2, 2, 1
        drive(2'b00, 2'b11, 1'b0);
        tick();
        drive(2'b00, 2'b11, 1'b0);
        tick();
        drive(2'b00, 2'b01, 1'b0);
        tick();
        chk("drain_count", int'(rif.count_o), 9);

        // Flush with every strobe active
        drive(2'b11, 2'b11, 1'b1);
        chk("flush_pvalid", int'(rif.p_valid_o), 0);
        tick();
        drive(2'b00, 2'b00, 1'b0);
        chk("flush_count", int'(rif.count_o), 0);
        chk("flush_rrrid", int'(rif.c_rrrid_o), 16);
        chk("flush_ready", int'(rif.p_ready_o), 1);
        chk("flush_empty", int'(rif.empty_o), 1);
        chk("flush_prid", int'(rif.p_rid_o), 16);
        chk("flush_err_kept", int'(rif.err_o), CHK);

        // Reset overrides strobes mid-operation
        rst = 1'b1;
        drive(2'b11, 2'b11, 1'b0);
        tick();
        rst = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        chk("rst2_err", int'(rif.err_o), 0);
        chk("rst2_count", int'(rif.count_o), 0);
        chk("rst2_ready", int'(rif.p_ready_o), 1);

        // Retire while empty sets the sticky error (check build)
        drive(2'b00, 2'b01, 1'b0);
        tick();
        drive(2'b00, 2'b00, 1'b0);
        chk("chk_err_set", int'(rif.err_o), CHK);
        tick();
        tick();
        tick();
        chk("chk_err_sticky", int'(rif.err_o), CHK);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("chk_err_clr", int'(rif.err_o), 0);
        chk("chk_count_clr", int'(rif.count_o), 0);
        chk("chk_empty_clr", int'(rif.empty_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
